// File: rtl/core_reg_write_arbiter.sv
// Register bank shared by several write requesters: round-robin arbitration with
// optional bounded lock bursts, plus one combinational read port.
module core_reg_write_arbiter #(
    parameter int unsigned     Requesters = 4,
    parameter int unsigned     Bits       = 8,
    parameter int unsigned     Depth      = 16,
    parameter int unsigned     MaxBurst   = 4,
    parameter logic [Bits-1:0] ResetValue = '0,
    localparam int unsigned    AddrBits   = $clog2(Depth)
) (
    input  logic                           clk_i,
    input  logic                           rst_i,
    input  logic [Requesters-1:0]          req_valid_i,
    input  logic [Requesters-1:0]          req_lock_i,
    input  logic [Requesters*AddrBits-1:0] req_addr_i,
    input  logic [Requesters*Bits-1:0]     req_data_i,
    output logic [Requesters-1:0]          req_ready_o,
    output logic [Requesters-1:0]          grant_o,
    output logic                           busy_o,
    input  logic [AddrBits-1:0]            rd_addr_i,
    output logic [Bits-1:0]                rd_data_o
);

    localparam int unsigned PtrW = $clog2(Requesters);
    localparam int unsigned CntW = $clog2(MaxBurst + 1);

    typedef enum logic [0:0] {StIdle, StLocked} state_e;

    state_e          state_q, state_d;
    logic [PtrW-1:0] ptr_q, ptr_d;
    logic [PtrW-1:0] owner_q, owner_d;
    logic [CntW-1:0] cnt_q, cnt_d;
    logic [Bits-1:0] mem_q [Depth];
    logic [Bits-1:0] mem_d [Depth];

    logic            found;
    logic [PtrW-1:0] winner;
    logic [PtrW-1:0] sel;
    logic            accept;
    logic [AddrBits-1:0] wr_addr;
    logic [Bits-1:0]     wr_data;

    function automatic logic [PtrW-1:0] next_ptr(input logic [PtrW-1:0] p);
        return (32'(p) == Requesters - 1) ? '0 : p + 1'b1;
    endfunction

    // First valid requester at or above the pointer, wrapping around.
    always_comb begin
        found  = 1'b0;
        winner = '0;
        for (int unsigned i = 0; i < Requesters; i++) begin
            if (!found && req_valid_i[(32'(ptr_q) + i) % Requesters]) begin
                found  = 1'b1;
                winner = PtrW'((32'(ptr_q) + i) % Requesters);
            end
        end
    end

    always_comb begin
        req_ready_o = '0;
        grant_o     = '0;
        busy_o      = 1'b0;
        sel         = (state_q == StLocked) ? owner_q : winner;
        if (!rst_i) begin
            if (state_q == StLocked) begin
                req_ready_o[owner_q] = req_valid_i[owner_q];
                grant_o[owner_q]     = 1'b1;
                busy_o               = 1'b1;
            end else begin
                req_ready_o[winner] = found;
                grant_o             = req_ready_o;
            end
        end
        accept  = |req_ready_o;
        wr_addr = req_addr_i[32'(sel) * AddrBits +: AddrBits];
        wr_data = req_data_i[32'(sel) * Bits +: Bits];
    end

    always_comb begin
        state_d = state_q;
        ptr_d   = ptr_q;
        owner_d = owner_q;
        cnt_d   = cnt_q;
        unique case (state_q)
            StIdle: begin
                if (accept) begin
                    if (req_lock_i[winner] && MaxBurst > 1) begin
                        state_d = StLocked;
                        owner_d = winner;
                        cnt_d   = CntW'(1);
                    end else begin
                        ptr_d = next_ptr(winner);
                    end
                end
            end
            StLocked: begin
                if (accept) begin
                    if (req_lock_i[owner_q] && (32'(cnt_q) + 1 < MaxBurst)) begin
                        cnt_d = cnt_q + 1'b1;
                    end else begin
                        state_d = StIdle;
                        cnt_d   = '0;
                        ptr_d   = next_ptr(owner_q);
                    end
                end else if (!req_lock_i[owner_q]) begin
                    // Owner gave up the lock without writing: release silently.
                    state_d = StIdle;
                    cnt_d   = '0;
                    ptr_d   = next_ptr(owner_q);
                end
            end
            default: state_d = StIdle;
        endcase
    end

    // Out-of-range addresses complete the handshake but leave the bank untouched.
    always_comb begin
        mem_d = mem_q;
        if (accept && (32'(wr_addr) < Depth)) begin
            mem_d[wr_addr] = wr_data;
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q <= StIdle;
            ptr_q   <= '0;
            owner_q <= '0;
            cnt_q   <= '0;
            for (int i = 0; i < Depth; i++) begin
                mem_q[i] <= ResetValue;
            end
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            owner_q <= owner_d;
            cnt_q   <= cnt_d;
            mem_q   <= mem_d;
        end
    end

    assign rd_data_o = (32'(rd_addr_i) < Depth) ? mem_q[rd_addr_i] : '0;

endmodule

// File: doc/core_reg_write_arbiter.md
Name: core_reg_write_arbiter

Overview:
- Shares one bank of enable-gated data registers between several write requesters.
- Arbitrates round-robin and lets a requester lock the bank for a bounded burst of back-to-back writes.
- Provides a single combinational read port for the datapath.
- Sits between the producers (config, layer controllers) and the register storage in the core.

Parameters:
- Requesters, 4: number of write requesters, at least 2.
- Bits, 8: data width of each register.
- Depth, 16: number of registers in the bank.
- AddrBits, $clog2(Depth): address width, derived and not overridden.
- MaxBurst, 4: maximum accepted writes per lock tenure, at least 1.
- ResetValue, all-zero: reset value of every register.

Ports:
- clk_i  input  1  clock; all state updates on the rising edge.
- rst_i  input  1  reset, asynchronous, active-high.
- req_valid_i  input  Requesters  per-requester write request.
- req_lock_i  input  Requesters  per-requester request to hold the grant after this write.
- req_addr_i  input  Requesters*AddrBits  packed write addresses; requester k uses slice k.
- req_data_i  input  Requesters*Bits  packed write data; requester k uses slice k.
- req_ready_o  output  Requesters  one-hot-or-zero; write accepted when valid and ready.
- grant_o  output  Requesters  one-hot current owner when LOCKED, else equal to req_ready_o.
- busy_o  output  1  high while in LOCKED.
- rd_addr_i  input  AddrBits  read address.
- rd_data_o  output  Bits  combinational read of the register bank.

Behaviour:
- Reset (async, immediate) sets:
  - all registers to ResetValue
  - FSM to IDLE
  - round-robin pointer to 0 (requester 0 highest priority)
  - burst count to 0, owner to 0
  - req_ready_o, grant_o and busy_o to 0
  - rd_data_o then shows ResetValue, or 0 for an out-of-range address.
- Reset mid-burst: the lock and the pointer are abandoned; no partial write occurs.
- Arbitration is combinational, in the same cycle. At most one bit of req_ready_o is high, and never for a requester whose valid is low.
- Write latency: an accepted write updates the register on that clock edge. rd_data_o reflects the new value from the next cycle.
- Same-cycle read of an address being written returns the old value.
- IDLE:
  - Winner is the first valid requester, searching from the pointer upward with wrap-around. ready goes to the winner.
  - Accepted write with lock low: pointer becomes (winner+1) mod Requesters; stay IDLE.
  - Accepted write with lock high and MaxBurst>1: go to LOCKED; owner=winner; count=1; pointer unchanged.
  - Accepted write with lock high and MaxBurst=1: treated as lock low.
  - No valid requester: nothing changes.
- LOCKED:
  - Only the owner may get ready; all other requesters see ready=0 regardless of their valid.
  - Owner accepted, lock high, count+1<MaxBurst: stay LOCKED; count increments.
  - Owner accepted and (lock low or count+1=MaxBurst): go to IDLE; count=0; pointer=(owner+1) mod Requesters.
  - Owner valid low, lock high: stall, no write, state held (no timeout).
  - Owner valid low, lock low: release to IDLE without a write; pointer=(owner+1) mod Requesters. No other requester is granted that cycle.
- Out-of-range write address (Depth not a power of two): the handshake completes and counts toward the burst, but no register changes.
- Out-of-range read address: rd_data_o=0.
- Widths: count is $clog2(MaxBurst+1) bits; pointer is $clog2(Requesters) bits, wrapping explicitly at Requesters-1 → 0.

Test Plan:
- Reset behaviour: after reset with rd_addr_i=3 → rd_data_o=0, req_ready_o=0, busy_o=0. Assert rst_i mid-burst → busy_o drops immediately, with no clock edge needed.
- Round-robin fairness: all 4 requesters valid, no lock, each writing addr=k with data=0x10+k, held for 4 cycles → grants are 0,1,2,3 in order. Registers 0..3 then read 0x10..0x13.
- Burst cap: requester 2 valid with lock held high, requesters 0 and 1 also valid, MaxBurst=4 → exactly 4 consecutive writes by requester 2, then the grant goes to requester 3 if valid, else requester 0.
- Stall and release: in LOCKED, requester 1 drops valid and keeps lock for 3 cycles → no writes and no ready to anyone. It then drops lock → IDLE next cycle with pointer=2.
- Read/write collision: write 0xAB to addr 5 while rd_addr_i=5 → old value that cycle, 0xAB the following cycle.
- Out-of-range (Depth=12): write addr 14 → accepted but no register changes. Read addr 14 → 0.
